// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - buffers host operands, then issues one ALU cmd beat followed by the operand words
module alu_op_sequencer #(
    parameter int DEPTH     = 16,
    parameter int INT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INT_WIDTH-1:0] in_data,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic                 go,
    input  logic [2:0]           go_opcode,
    output logic                 go_rdy,
    input  logic                 alu_rdy,
    output logic [13:0]          cmd_o,
    output logic [INT_WIDTH:0]   word_o,
    output logic [9:0]           fill_cnt,
    output logic                 err_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [9:0]       DEPTH_C  = 10'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [2:0]       MAX_OP   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_STREAM
    } state_t;

    state_t               r_state;
    logic [INT_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [9:0]           r_fill;
    logic [9:0]           r_remain;
    logic [13:0]          r_cmd;
    logic [INT_WIDTH:0]   r_word;
    logic                 r_err;

    logic                 w_idle;
    logic                 w_in_rdy;
    logic                 w_push;
    logic                 w_go_ok;
    logic                 w_go_bad;
    logic [PTR_W-1:0]     w_wr_next;
    logic [PTR_W-1:0]     w_rd_next;

    assign w_idle    = (r_state == S_IDLE);
    // go wins over a simultaneous push so num_words matches what is already buffered
    assign w_in_rdy  = w_idle && (r_fill < DEPTH_C) && !go;
    assign w_push    = in_vld && w_in_rdy;
    assign w_go_ok   = w_idle && go && (r_fill != 10'd0) && (go_opcode <= MAX_OP);
    assign w_go_bad  = w_idle && go && !w_go_ok;
    assign w_wr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

    assign in_rdy   = w_in_rdy;
    assign go_rdy   = w_idle;
    assign cmd_o    = r_cmd;
    assign word_o   = r_word;
    assign fill_cnt = r_fill;
    assign err_o    = r_err;

    // storage only; contents are meaningless after reset because the pointers clear
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_remain <= '0;
            r_cmd    <= '0;
            r_word   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_err <= w_go_bad;
                    if (w_push) begin
                        r_wr_ptr <= w_wr_next;
                        r_fill   <= r_fill + 10'd1;
                    end
                    if (w_go_ok) begin
                        r_cmd    <= {1'b1, go_opcode, r_fill};
                        r_remain <= r_fill;
                        r_state  <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (alu_rdy) begin
                        r_cmd   <= '0;
                        r_word  <= {1'b1, r_mem[r_rd_ptr]};
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (alu_rdy) begin
                        r_rd_ptr <= w_rd_next;
                        r_fill   <= r_fill - 10'd1;
                        r_remain <= r_remain - 10'd1;
                        // prefetch the next head so back-to-back pops run without a bubble
                        if (r_remain <= 10'd1) begin
                            r_word  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_word <= {1'b1, r_mem[w_rd_next]};
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    localparam int         DEPTH = 16;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_MEAN = 3'd4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_vld;
    logic        in_rdy;
    logic        go;
    logic [2:0]  go_opcode;
    logic        go_rdy;
    logic        alu_rdy;
    logic [13:0] cmd_o;
    logic [8:0]  word_o;
    logic [9:0]  fill_cnt;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  model_q[$];
    logic [13:0] got_cmd[$];
    logic [7:0]  got_words[$];

    logic        p_valid;
    logic [13:0] p_cmd;
    logic [8:0]  p_word;
    logic        p_rdy;

    alu_op_sequencer #(.DEPTH(DEPTH), .INT_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .go        (go),
        .go_opcode (go_opcode),
        .go_rdy    (go_rdy),
        .alu_rdy   (alu_rdy),
        .cmd_o     (cmd_o),
        .word_o    (word_o),
        .fill_cnt  (fill_cnt),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // handshake recorder and protocol watcher, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            p_valid = 1'b0;
        end else begin
            check("cmd_word_exclusive", {31'd0, cmd_o[13] && word_o[8]}, 32'd0);
            if (p_valid && p_cmd[13] && !p_rdy) check("cmd_hold", {18'd0, cmd_o}, {18'd0, p_cmd});
            if (p_valid && p_word[8] && !p_rdy) check("word_hold", {23'd0, word_o}, {23'd0, p_word});
            if (cmd_o[13] && alu_rdy) got_cmd.push_back(cmd_o);
            if (word_o[8] && alu_rdy) got_words.push_back(word_o[7:0]);
            p_valid = 1'b1;
            p_cmd   = cmd_o;
            p_word  = word_o;
            p_rdy   = alu_rdy;
        end
    end

    task automatic push(input logic [7:0] w);
        logic exp_rdy;
        @(posedge clk); #1;
        go      = 1'b0;
        in_vld  = 1'b1;
        in_data = w;
        exp_rdy = (model_q.size() < DEPTH);
        @(negedge clk);
        check("fill_before_push", {22'd0, fill_cnt}, model_q.size());
        check("in_rdy", {31'd0, in_rdy}, {31'd0, exp_rdy});
        if (exp_rdy) model_q.push_back(w);
    endtask

    task automatic do_go(input logic [2:0] op, input bit with_push, input int rdy_pct);
        int          n;
        int          base_c;
        int          base_w;
        int          cyc;
        bit          exp_err;
        logic [7:0]  exp_q[$];
        logic [13:0] exp_cmd;
        n       = model_q.size();
        exp_err = (n == 0) || (op > 3'd4);
        exp_cmd = {1'b1, op, 10'(n)};
        base_c  = got_cmd.size();
        base_w  = got_words.size();
        @(posedge clk); #1;
        go        = 1'b1;
        go_opcode = op;
        in_vld    = with_push;
        in_data   = 8'hA5;
        alu_rdy   = ($urandom_range(99) < rdy_pct);
        @(negedge clk);
        check("go_rdy_idle", {31'd0, go_rdy}, 32'd1);
        check("in_rdy_during_go", {31'd0, in_rdy}, 32'd0);
        @(posedge clk); #1;
        go     = 1'b0;
        in_vld = 1'b0;
        @(negedge clk); #1;
        if (exp_err) begin
            check("err_pulse", {31'd0, err_o}, 32'd1);
            check("err_no_cmd", {31'd0, cmd_o[13]}, 32'd0);
            check("err_fill_kept", {22'd0, fill_cnt}, n);
            @(negedge clk); #1;
            check("err_single", {31'd0, err_o}, 32'd0);
            check("err_cmd_count", got_cmd.size() - base_c, 32'd0);
            check("err_go_rdy", {31'd0, go_rdy}, 32'd1);
        end else begin
            check("err_none", {31'd0, err_o}, 32'd0);
            check("cmd_value", {18'd0, cmd_o}, {18'd0, exp_cmd});
            exp_q = model_q;
            model_q.delete();
            cyc = 0;
            while ((got_words.size() - base_w < n) && cyc < 400) begin
                @(posedge clk); #1;
                alu_rdy = ($urandom_range(99) < rdy_pct);
                cyc++;
            end
            check("burst_timeout", {31'd0, cyc < 400}, 32'd1);
            @(negedge clk); #1;
            check("end_word_vld", {31'd0, word_o[8]}, 32'd0);
            check("end_cmd_vld", {31'd0, cmd_o[13]}, 32'd0);
            check("end_go_rdy", {31'd0, go_rdy}, 32'd1);
            check("end_fill", {22'd0, fill_cnt}, 32'd0);
            check("cmd_count", got_cmd.size() - base_c, 32'd1);
            if (got_cmd.size() > base_c) check("cmd_beat", {18'd0, got_cmd[base_c]}, {18'd0, exp_cmd});
            check("word_count", got_words.size() - base_w, n);
            for (int i = 0; i < n; i++) begin
                if (base_w + i < got_words.size())
                    check("word_data", {24'd0, got_words[base_w + i]}, {24'd0, exp_q[i]});
            end
        end
    endtask

    task automatic reset_mid_stream();
        int base_c;
        int base_w;
        int cyc;
        for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
        base_c = got_cmd.size();
        base_w = got_words.size();
        @(posedge clk); #1;
        in_vld    = 1'b0;
        go        = 1'b1;
        go_opcode = OP_MUL;
        alu_rdy   = 1'b1;
        @(posedge clk); #1;
        go  = 1'b0;
        cyc = 0;
        while ((got_words.size() - base_w < 2) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_pre_timeout", {31'd0, cyc < 50}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_cmd", {18'd0, cmd_o}, 32'd0);
        check("rst_word", {23'd0, word_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_fill", {22'd0, fill_cnt}, 32'd0);
        model_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check("post_rst_go_rdy", {31'd0, go_rdy}, 32'd1);
        check("post_rst_fill", {22'd0, fill_cnt}, 32'd0);
        check("post_rst_word", {23'd0, word_o}, 32'd0);
        check("post_rst_cmds", got_cmd.size() - base_c, 32'd1);
        check("post_rst_words", got_words.size() - base_w, 32'd2);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'd0;
        in_vld    = 1'b0;
        go        = 1'b0;
        go_opcode = 3'd0;
        alu_rdy   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_cmd", {18'd0, cmd_o}, 32'd0);
        check("reset_word", {23'd0, word_o}, 32'd0);
        check("reset_err", {31'd0, err_o}, 32'd0);
        check("reset_fill", {22'd0, fill_cnt}, 32'd0);
        check("reset_go_rdy", {31'd0, go_rdy}, 32'd1);
        check("reset_in_rdy", {31'd0, in_rdy}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        push(8'd3);
        push(8'd7);
        push(8'd250);
        do_go(OP_ADD, 1'b0, 100);

        for (int i = 0; i < DEPTH + 1; i++) push(8'(i + 1));
        @(posedge clk); #1;
        in_vld = 1'b0;
        @(negedge clk);
        check("full_fill", {22'd0, fill_cnt}, DEPTH);
        check("full_in_rdy", {31'd0, in_rdy}, 32'd0);
        do_go(OP_MEAN, 1'b0, 100);
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        do_go(OP_MEAN, 1'b0, 100);

        do_go(OP_ADD, 1'b0, 100);
        push(8'h11);
        push(8'h22);
        do_go(3'd6, 1'b0, 100);
        for (int i = 0; i < 3; i++) push(8'($urandom));
        do_go(OP_MUL, 1'b0, 50);

        for (int i = 0; i < 4; i++) push(8'($urandom));
        do_go(OP_ADD, 1'b1, 100);

        reset_mid_stream();

        for (int k = 0; k < 8; k++) begin
            int cnt;
            cnt = $urandom_range(1, DEPTH);
            for (int i = 0; i < cnt; i++) push(8'($urandom));
            do_go(3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), $urandom_range(30, 100));
            if (model_q.size() > 0) do_go(3'($urandom_range(0, 4)), 1'b0, $urandom_range(30, 100));
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
